// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined Wallace-tree multiplier: stage count, operand mode
// and the helpers that size the carry-save reduction tree.
package mul_pkg;

    localparam int unsigned MUL_STAGES = 3;

    typedef enum logic {
        MUL_UNSIGNED = 1'b0,
        MUL_SIGNED   = 1'b1
    } mul_mode_e;

    // Rows left after `levels` rounds of 3:2 compression (each round turns 3 rows into 2).
    function automatic int unsigned csa_rows_after(int unsigned rows, int unsigned levels);
        int unsigned n;
        n = rows;
        for (int unsigned l = 0; l < levels; l++) begin
            if (n > 2) n = n - n / 3;
        end
        return n;
    endfunction

    function automatic int unsigned csa_levels(int unsigned rows);
        int unsigned n;
        int unsigned lv;
        n  = rows;
        lv = 0;
        while (n > 2) begin
            n  = n - n / 3;
            lv = lv + 1;
        end
        return lv;
    endfunction

endpackage

// File: rtl/csa_row.sv
// W-bit 3:2 carry-save compressor; the carry row is returned already weighted (shifted left).
module csa_row #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    assign sum   = a ^ b ^ c;
    assign carry = ((a & b) | (a & c) | (b & c)) << 1;

endmodule

// File: rtl/wallace_pipe_mul.sv
// Three-stage pipelined WIDTH x WIDTH multiplier: partial products, CSA tree, final add.
// Signed mode uses modified Baugh-Wooley so both modes share one unsigned-style tree.
module wallace_pipe_mul
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int unsigned PW     = 2 * WIDTH;
    localparam int unsigned LEVELS = csa_levels(WIDTH);

    if (WIDTH < 4 || WIDTH > 64) begin : g_width_check
        $error("wallace_pipe_mul: WIDTH must be within 4..64");
    end

    logic [MUL_STAGES-1:0] v_q, v_d;
    logic                  adv1, adv2, adv3;

    assign adv3     = v_q[1] & (~v_q[2] | out_ready);
    assign adv2     = v_q[0] & (~v_q[1] | adv3);
    assign in_ready = ~v_q[0] | adv2;
    assign adv1     = in_valid & in_ready;

    always_comb begin
        v_d    = v_q;
        v_d[0] = adv1 | (v_q[0] & ~adv2);
        v_d[1] = adv2 | (v_q[1] & ~adv3);
        v_d[2] = adv3 | (v_q[2] & ~out_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    // S1: partial products; in signed mode the cross terms with exactly one sign bit invert.
    logic [WIDTH-1:0] pp_d [WIDTH];
    logic [WIDTH-1:0] pp_q [WIDTH];
    mul_mode_e        mode_q;
    logic [TAG_W-1:0] tag1_q;

    always_comb begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
            for (int unsigned j = 0; j < WIDTH; j++) begin
                pp_d[i][j] = (in_a[j] & in_b[i]) ^
                             (in_signed & ((i == WIDTH - 1) != (j == WIDTH - 1)));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv1) begin
            pp_q   <= pp_d;
            mode_q <= in_signed ? MUL_SIGNED : MUL_UNSIGNED;
            tag1_q <= in_tag;
        end
    end

    // S2: weight each row and fold the Baugh-Wooley constants (2^W, 2^(2W-1)) into free
    // bit positions of the first and last rows so no extra row is needed.
    logic [PW-1:0] tree [LEVELS+1][WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_rows
        localparam logic [PW-1:0] CORR = (i == 0)         ? (PW'(1) << WIDTH)  :
                                         (i == WIDTH - 1) ? (PW'(1) << (PW-1)) : '0;
        assign tree[0][i] = ({{WIDTH{1'b0}}, pp_q[i]} << i) |
                            ((mode_q == MUL_SIGNED) ? CORR : '0);
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int unsigned NIN = csa_rows_after(WIDTH, l);
        localparam int unsigned NG  = NIN / 3;
        for (genvar g = 0; g < NG; g++) begin : g_csa
            csa_row #(
                .W(PW)
            ) u_csa (
                .a    (tree[l][3*g]),
                .b    (tree[l][3*g+1]),
                .c    (tree[l][3*g+2]),
                .sum  (tree[l+1][2*g]),
                .carry(tree[l+1][2*g+1])
            );
        end
        for (genvar r = 3 * NG; r < NIN; r++) begin : g_pass
            assign tree[l+1][r-NG] = tree[l][r];
        end
        for (genvar k = NIN - NG; k < WIDTH; k++) begin : g_unused
            assign tree[l+1][k] = '0;
        end
    end

    logic [PW-1:0]    sum_q, carry_q;
    logic [TAG_W-1:0] tag2_q;

    always_ff @(posedge clk) begin
        if (adv2) begin
            sum_q   <= tree[LEVELS][0];
            carry_q <= tree[LEVELS][1];
            tag2_q  <= tag1_q;
        end
    end

    // S3: carry-propagate add; output registers are the only source of the out_* ports.
    logic [PW-1:0]    prod_q;
    logic [TAG_W-1:0] tag3_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
            tag3_q <= '0;
        end else if (adv3) begin
            prod_q <= sum_q + carry_q;
            tag3_q <= tag2_q;
        end
    end

    assign out_valid = v_q[2];
    assign out_prod  = prod_q;
    assign out_tag   = tag3_q;

endmodule

// File: tb/tb_wallace_pipe_mul.sv
// Scoreboard bench for wallace_pipe_mul at WIDTH=32 and WIDTH=8.
module tb_wallace_pipe_mul;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, in_signed, out_valid, out_ready;
    logic [31:0] in_a, in_b;
    logic [3:0]  in_tag, out_tag;
    logic [63:0] out_prod;

    logic        in_valid8, in_ready8, in_signed8, out_valid8, out_ready8;
    logic [7:0]  in_a8, in_b8;
    logic [3:0]  in_tag8, out_tag8;
    logic [15:0] out_prod8;

    wallace_pipe_mul #(.WIDTH(32), .TAG_W(4)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
        .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_prod(out_prod), .out_tag(out_tag)
    );

    wallace_pipe_mul #(.WIDTH(8), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_a(in_a8),
        .in_b(in_b8), .in_signed(in_signed8), .in_tag(in_tag8), .out_valid(out_valid8),
        .out_ready(out_ready8), .out_prod(out_prod8), .out_tag(out_tag8)
    );

    typedef struct {
        logic [63:0] prod;
        logic [3:0]  tag;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] model32(logic [31:0] a, logic [31:0] b, logic s);
        logic [63:0] ea, eb;
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    function automatic logic [15:0] model8(logic [7:0] a, logic [7:0] b, logic s);
        logic [15:0] ea, eb;
        ea = s ? {{8{a[7]}}, a} : {8'b0, a};
        eb = s ? {{8{b[7]}}, b} : {8'b0, b};
        return ea * eb;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q32.size() == 0) begin
                chk("spurious32", 1, 0);
            end else begin
                exp_t e;
                e = q32.pop_front();
                chk("prod32", out_prod, e.prod);
                chk("tag32", out_tag, e.tag);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid8 && out_ready8) begin
            if (q8.size() == 0) begin
                chk("spurious8", 1, 0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("prod8", out_prod8, e.prod);
                chk("tag8", out_tag8, e.tag);
            end
        end
    end

    task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [3:0] t, input logic [63:0] e);
        in_a = a; in_b = b; in_signed = s; in_tag = t; in_valid = 1'b1;
        @(negedge clk);
        for (int w = 0; w < 50 && !in_ready; w++) @(negedge clk);
        if (in_ready) q32.push_back('{prod: e, tag: t});
        else chk("accept32_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [3:0] t);
        in_a8 = a; in_b8 = b; in_signed8 = s; in_tag8 = t; in_valid8 = 1'b1;
        @(negedge clk);
        for (int w = 0; w < 50 && !in_ready8; w++) @(negedge clk);
        if (in_ready8) q8.push_back('{prod: {48'b0, model8(a, b, s)}, tag: t});
        else chk("accept8_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic drain32();
        for (int w = 0; w < 50 && q32.size() != 0; w++) @(negedge clk);
        chk("drain32", q32.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic drain8();
        for (int w = 0; w < 50 && q8.size() != 0; w++) @(negedge clk);
        chk("drain8", q8.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b;
        logic        s;
        logic [63:0] held_p;
        logic [3:0]  held_t;
        int          acc, t0;
        int          bv[48];

        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0;
        out_ready = 1'b1;
        in_valid8 = 1'b0; in_a8 = '0; in_b8 = '0; in_signed8 = 1'b0; in_tag8 = '0;
        out_ready8 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_prod", out_prod, 0);
        chk("reset_out_tag", out_tag, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed products and first-beat latency.
        send32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'h5, 64'hFFFF_FFFE_0000_0001);
        @(negedge clk); chk("lat_n1", out_valid, 0);
        @(negedge clk); chk("lat_n2", out_valid, 0);
        @(negedge clk); chk("lat_n3", out_valid, 1);
        drain32();
        send32(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 4'h1, 64'hFFFF_FFFF_FFFF_FFFE);
        send32(32'h8000_0000, 32'h8000_0000, 1'b1, 4'h2, 64'h4000_0000_0000_0000);
        send32(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 4'h3, 64'hC000_0000_8000_0000);
        send32(32'h8000_0000, 32'h8000_0000, 1'b0, 4'h4, 64'h4000_0000_0000_0000);
        drain32();

        // Continuous random stream, mixed modes.
        t0 = cyc;
        for (int i = 0; i < 100; i++) begin
            a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
            if (i % 10 == 0) a = 32'h8000_0000;
            send32(a, b, s, 4'(i % 16), model32(a, b, s));
        end
        chk("stream_cycles", cyc - t0, 100);
        drain32();

        // Backpressure: stall the consumer for 5 cycles with input always offered.
        out_ready = 1'b0; acc = 0;
        a = $urandom; b = $urandom; s = 1'b1;
        in_a = a; in_b = b; in_signed = s; in_tag = 4'd8; in_valid = 1'b1;
        held_p = '0; held_t = '0;
        for (int c = 0; c < 5; c++) begin
            logic took;
            @(negedge clk);
            if (c == 3) begin held_p = out_prod; held_t = out_tag; end
            if (c == 4) begin
                chk("stall_prod", out_prod, held_p);
                chk("stall_tag", out_tag, held_t);
                chk("stall_valid", out_valid, 1);
            end
            took = in_ready;
            if (took) begin
                q32.push_back('{prod: model32(a, b, s), tag: in_tag});
                acc++;
            end
            @(posedge clk); #1;
            if (took) begin
                a = $urandom; b = $urandom; s = ~s;
                in_a = a; in_b = b; in_signed = s; in_tag = 4'(8 + acc);
            end
        end
        chk("bp_accepted", acc, 3);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_hold_prod", out_prod, held_p);
        in_valid = 1'b0; out_ready = 1'b1;
        drain32();

        // Bubble collapse: second beat two cycles behind the first with the output stalled.
        out_ready = 1'b0;
        in_a = 32'd7; in_b = 32'd9; in_signed = 1'b0; in_tag = 4'hA; in_valid = 1'b1;
        @(negedge clk); chk("bub_rdy0", in_ready, 1);
        q32.push_back('{prod: 64'd63, tag: 4'hA});
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk); chk("bub_rdy1", in_ready, 1);
        @(posedge clk); #1;
        in_a = 32'hFFFF_FFFD; in_b = 32'd3; in_signed = 1'b1; in_tag = 4'hB; in_valid = 1'b1;
        @(negedge clk); chk("bub_rdy2", in_ready, 1);
        q32.push_back('{prod: 64'hFFFF_FFFF_FFFF_FFF7, tag: 4'hB});
        @(posedge clk); #1;
        in_a = 32'd100; in_b = 32'd200; in_signed = 1'b0; in_tag = 4'hC;
        @(negedge clk);
        chk("bub_rdy3", in_ready, 1);
        chk("bub_valid", out_valid, 1);
        q32.push_back('{prod: 64'd20000, tag: 4'hC});
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk); chk("bub_full", in_ready, 0);
        @(posedge clk); #1; out_ready = 1'b1;
        drain32();

        // Reset with three beats in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom;
            send32(a, b, 1'b0, 4'(i), model32(a, b, 1'b0));
        end
        chk("pre_rst_valid", out_valid, 1);
        #2; rst = 1'b1; #1;
        chk("rst_async_valid", out_valid, 0);
        chk("rst_async_ready", in_ready, 1);
        chk("rst_async_prod", out_prod, 0);
        q32.delete();
        @(posedge clk); #1; rst = 1'b0; out_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst_idle_valid", out_valid, 0);
        chk("rst_idle_ready", in_ready, 1);
        @(posedge clk); #1;
        send32(32'd12345, 32'd678, 1'b0, 4'hE, 64'd8369910);
        drain32();

        // WIDTH=8: every multiplicand against a spread of multipliers, both modes.
        for (int k = 0; k < 16; k++) begin
            bv[k] = k; bv[16 + k] = 120 + k; bv[32 + k] = 240 + k;
        end
        t0 = 0;
        for (int sm = 0; sm < 2; sm++) begin
            for (int ai = 0; ai < 256; ai++) begin
                for (int bi = 0; bi < 48; bi++) begin
                    send8(8'(ai), 8'(bv[bi]), 1'(sm), 4'(t0 % 16));
                    t0++;
                end
            end
        end
        drain8();

        // WIDTH=8 reset with beats in flight.
        out_ready8 = 1'b0;
        for (int i = 0; i < 3; i++) send8(8'(37 * i + 5), 8'hC3, 1'b1, 4'(i));
        chk("rst8_pre_valid", out_valid8, 1);
        #2; rst = 1'b1; #1;
        chk("rst8_async_valid", out_valid8, 0);
        chk("rst8_async_ready", in_ready8, 1);
        q8.delete();
        @(posedge clk); #1; rst = 1'b0; out_ready8 = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst8_idle_valid", out_valid8, 0);
        @(posedge clk); #1;
        send8(8'h80, 8'h80, 1'b1, 4'h9);
        drain8();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
